// File: rtl/mem_txn_arbiter.sv
// Transaction-level arbiter between CPU, UART and VGA onto a single memory port.
// VGA has absolute priority; CPU and UART share the remaining bandwidth by weight.
module mem_txn_arbiter #(
   parameter int unsigned CPU_WEIGHT = 4
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic [1:0]  VGA_state,
   input  logic [2:0]  req,
   input  logic [2:0]  we,
   input  logic [95:0] adr_in,
   input  logic [95:0] wdata_in,
   input  logic [11:0] sel_in,
   output logic [2:0]  ack,
   output logic [31:0] rdata,
   output logic [1:0]  grant,
   output logic        write_to_mem,
   output logic        read_to_mem,
   output logic [31:0] adr_to_mem,
   output logic [31:0] data_to_mem,
   output logic [3:0]  sel_to_mem,
   input  logic [31:0] data_from_mem,
   input  logic        mem_busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   localparam logic [1:0] GrNone = 2'd0;
   localparam logic [1:0] GrCpu  = 2'd1;
   localparam logic [1:0] GrVga  = 2'd2;
   localparam logic [1:0] GrUart = 2'd3;
   localparam logic [7:0] Weight = 8'(CPU_WEIGHT);

   state_e      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  cpu_run_q, cpu_run_d;

   logic        vga_hold;
   logic [1:0]  win_grant;
   logic        win_we;
   logic [31:0] win_adr;
   logic [31:0] win_wdata;
   logic [3:0]  win_sel;

   // VGA_state value 3 counts as inactive.
   assign vga_hold = (VGA_state == 2'd1) || (VGA_state == 2'd2);

   always_comb begin
      win_grant = GrNone;
      if (req[2]) begin
         win_grant = GrVga;
      end else if (!vga_hold) begin
         if (req[0] && req[1]) begin
            win_grant = (cpu_run_q == Weight) ? GrUart : GrCpu;
         end else if (req[0]) begin
            win_grant = GrCpu;
         end else if (req[1]) begin
            win_grant = GrUart;
         end
      end
   end

   always_comb begin
      win_we    = 1'b0;
      win_adr   = '0;
      win_wdata = '0;
      win_sel   = '0;
      unique case (win_grant)
         GrCpu: begin
            win_we    = we[0];
            win_adr   = adr_in[31:0];
            win_wdata = wdata_in[31:0];
            win_sel   = sel_in[3:0];
         end
         GrUart: begin
            win_we    = we[1];
            win_adr   = adr_in[63:32];
            win_wdata = wdata_in[63:32];
            win_sel   = sel_in[7:4];
         end
         GrVga: begin
            win_we    = we[2];
            win_adr   = adr_in[95:64];
            win_wdata = wdata_in[95:64];
            win_sel   = sel_in[11:8];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      we_d      = we_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      rdata_d   = rdata_q;
      cpu_run_d = cpu_run_q;
      unique case (state_q)
         StIdle: begin
            if (win_grant != GrNone) begin
               grant_d = win_grant;
               we_d    = win_we;
               adr_d   = win_adr;
               wdata_d = win_wdata;
               sel_d   = win_sel;
               state_d = StIssue;
               // Run length only counts CPU grants that made UART wait.
               if (win_grant == GrCpu) begin
                  if (!req[1]) begin
                     cpu_run_d = '0;
                  end else if (cpu_run_q != Weight) begin
                     cpu_run_d = cpu_run_q + 8'd1;
                  end
               end else if (win_grant == GrUart) begin
                  cpu_run_d = '0;
               end
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (!mem_busy) begin
               if (!we_q) begin
                  rdata_d = data_from_mem;
               end
               state_d = StDone;
            end
         end
         StDone: begin
            grant_d = GrNone;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q   <= StIdle;
         grant_q   <= GrNone;
         we_q      <= 1'b0;
         adr_q     <= '0;
         wdata_q   <= '0;
         sel_q     <= '0;
         rdata_q   <= '0;
         cpu_run_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         sel_q     <= sel_d;
         rdata_q   <= rdata_d;
         cpu_run_q <= cpu_run_d;
      end
   end

   always_comb begin
      write_to_mem = 1'b0;
      read_to_mem  = 1'b0;
      adr_to_mem   = '0;
      data_to_mem  = '0;
      sel_to_mem   = '0;
      ack          = '0;
      unique case (state_q)
         StIssue: begin
            write_to_mem = we_q;
            read_to_mem  = ~we_q;
            adr_to_mem   = adr_q;
            data_to_mem  = wdata_q;
            sel_to_mem   = sel_q;
         end
         StWait: begin
            adr_to_mem  = adr_q;
            data_to_mem = wdata_q;
            sel_to_mem  = sel_q;
         end
         StDone: begin
            unique case (grant_q)
               GrCpu:   ack = 3'b001;
               GrUart:  ack = 3'b010;
               GrVga:   ack = 3'b100;
               default: ack = 3'b000;
            endcase
         end
         default: ;
      endcase
   end

   assign grant = grant_q;
   assign rdata = rdata_q;

endmodule
